// File: rtl/pc_ir_unit.sv
// Program counter and instruction register for a multicycle 16-bit datapath.
// Handles fetch, decode-time branch-target capture, conditional branches and jumps.
module pc_ir_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        IRWrite,
    input  logic        PCBEqCond,
    input  logic        PCBNqCond,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    input  logic [15:0] imem_rdata,
    output logic [15:0] pc,
    output logic [15:0] pc_cur,
    output logic [15:0] ir,
    output logic [3:0]  opcode,
    output logic [3:0]  func_field,
    output logic        br_taken,
    output logic        br_err,
    output logic [15:0] retired
);

    logic [15:0] r_pc;
    logic [15:0] r_pcCur;
    logic [15:0] r_ir;
    logic [15:0] r_brTarget;
    logic [15:0] r_retired;
    logic        r_decode;
    logic        r_brTaken;
    logic        r_brErr;

    logic        w_illegal;
    logic        w_cond;
    logic        w_pcWriteEn;
    logic [15:0] w_jumpTarget;
    logic [15:0] w_branchCalc;
    logic [15:0] w_pcNext;

    assign w_illegal    = PCBEqCond & PCBNqCond;
    assign w_cond       = (PCBEqCond & ~PCBNqCond & alu_zero) |
                          (PCBNqCond & ~PCBEqCond & ~alu_zero);
    assign w_pcWriteEn  = PCWrite | w_cond;
    assign w_jumpTarget = {r_pcCur[15:12], r_ir[11:0]};
    assign w_branchCalc = r_pc + {{8{r_ir[7]}}, r_ir[7:0]};

    // An explicit PCWrite always outranks a conditional branch.
    always_comb begin
        w_pcNext = r_pc;
        if (PCWrite) begin
            case (PCSrc)
                2'b00:   w_pcNext = alu_result;
                2'b01:   w_pcNext = w_jumpTarget;
                2'b10:   w_pcNext = r_brTarget;
                default: w_pcNext = r_pc;
            endcase
        end else if (w_cond) begin
            w_pcNext = r_brTarget;
        end
    end

    // IR captures the word at the pre-update pc, so fetch and pc update can share an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_pcCur    <= 16'h0000;
            r_ir       <= 16'h0000;
            r_brTarget <= 16'h0000;
            r_retired  <= 16'h0000;
            r_decode   <= 1'b0;
            r_brTaken  <= 1'b0;
            r_brErr    <= 1'b0;
        end else begin
            if (w_pcWriteEn) begin
                r_pc <= w_pcNext;
            end
            if (IRWrite) begin
                r_ir      <= imem_rdata;
                r_pcCur   <= r_pc;
                r_retired <= r_retired + 16'h0001;
            end
            if (r_decode) begin
                r_brTarget <= w_branchCalc;
            end
            r_decode  <= IRWrite;
            r_brTaken <= w_cond & ~PCWrite;
            if (w_illegal) begin
                r_brErr <= 1'b1;
            end
        end
    end

    assign pc         = r_pc;
    assign pc_cur     = r_pcCur;
    assign ir         = r_ir;
    assign opcode     = r_ir[15:12];
    assign func_field = r_ir[3:0];
    assign br_taken   = r_brTaken;
    assign br_err     = r_brErr;
    assign retired    = r_retired;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed bench for pc_ir_unit: fetch, branches, jumps, illegal strobes and reset.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_pc_ir_unit;

    logic        clk;
    logic        rst;
    logic        PCWrite;
    logic        IRWrite;
    logic        PCBEqCond;
    logic        PCBNqCond;
    logic [1:0]  PCSrc;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic [15:0] imem_rdata;
    logic [15:0] pc;
    logic [15:0] pc_cur;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  func_field;
    logic        br_taken;
    logic        br_err;
    logic [15:0] retired;

    int testsRun;
    int failCount;

    pc_ir_unit #(.RESET_PC(16'h0100)) dut (
        .clk        (clk),
        .rst        (rst),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .PCBEqCond  (PCBEqCond),
        .PCBNqCond  (PCBNqCond),
        .PCSrc      (PCSrc),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .pc_cur     (pc_cur),
        .ir         (ir),
        .opcode     (opcode),
        .func_field (func_field),
        .br_taken   (br_taken),
        .br_err     (br_err),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic iRst, input logic iPcW, input logic iIrW,
                                 input logic iBeq, input logic iBnq, input logic [1:0] iSrc,
                                 input logic [15:0] iAlu, input logic iZero,
                                 input logic [15:0] iMem);
        rst        = iRst;
        PCWrite    = iPcW;
        IRWrite    = iIrW;
        PCBEqCond  = iBeq;
        PCBNqCond  = iBnq;
        PCSrc      = iSrc;
        alu_result = iAlu;
        alu_zero   = iZero;
        imem_rdata = iMem;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000);
        checkOutput("reset_pc", pc, 16'h0100);
        checkOutput("reset_ir", ir, 16'h0000);
        checkOutput("reset_pc_cur", pc_cur, 16'h0000);
        checkOutput("reset_retired", retired, 16'h0000);
        checkOutput("reset_opcode", {12'h000, opcode}, 16'h0000);
        checkOutput("reset_func", {12'h000, func_field}, 16'h0000);
        checkOutput("reset_br_err", {15'h0, br_err}, 16'h0000);
        checkOutput("reset_br_taken", {15'h0, br_taken}, 16'h0000);

        idle();
        checkOutput("hold_pc", pc, 16'h0100);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000);
        checkOutput("set_pc0", pc, 16'h0000);

        // Fetch with simultaneous pc update
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0001, 1'b0, 16'h8123);
        checkOutput("fetch_ir", ir, 16'h8123);
        checkOutput("fetch_pc_cur", pc_cur, 16'h0000);
        checkOutput("fetch_pc", pc, 16'h0001);
        checkOutput("fetch_opcode", {12'h000, opcode}, 16'h0008);
        checkOutput("fetch_func", {12'h000, func_field}, 16'h0003);
        checkOutput("fetch_retired", retired, 16'h0001);

        // BEQ taken: target = 0x0011 + sext(0xFE) = 0x000F
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0010, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0011, 1'b0, 16'h40FE);
        checkOutput("beq_fetch_pc_cur", pc_cur, 16'h0010);
        checkOutput("beq_fetch_pc", pc, 16'h0011);
        checkOutput("beq_retired", retired, 16'h0002);
        idle();
        idle();
        checkOutput("beq_decode_hold_pc", pc, 16'h0011);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b1, 16'h0000);
        checkOutput("beq_taken_pc", pc, 16'h000F);
        checkOutput("beq_taken_pulse", {15'h0, br_taken}, 16'h0001);
        idle();
        checkOutput("beq_pulse_end", {15'h0, br_taken}, 16'h0000);
        checkOutput("beq_pc_stable", pc, 16'h000F);

        // BNQ: not taken with alu_zero=1, then taken with alu_zero=0
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0010, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0011, 1'b0, 16'h40FE);
        idle();
        idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0000, 1'b1, 16'h0000);
        checkOutput("bnq_not_taken_pc", pc, 16'h0011);
        checkOutput("bnq_not_taken_flag", {15'h0, br_taken}, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0000, 1'b0, 16'h0000);
        checkOutput("bnq_taken_pc", pc, 16'h000F);
        checkOutput("bnq_taken_pulse", {15'h0, br_taken}, 16'h0001);

        // A taken condition under PCWrite follows PCSrc and does not pulse br_taken
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0040, 1'b1, 16'h0000);
        checkOutput("pcwrite_prio_pc", pc, 16'h0040);
        checkOutput("pcwrite_prio_no_pulse", {15'h0, br_taken}, 16'h0000);

        // Jump: {0x5, 0xABC}; decode edge captures 0x5001 + sext(0xBC) = 0x4FBD
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h5000, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 16'h5001, 1'b0, 16'h3ABC);
        checkOutput("jmp_pc_cur", pc_cur, 16'h5000);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h0000, 1'b0, 16'h0000);
        checkOutput("jmp_pc", pc, 16'h5ABC);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 16'h0000, 1'b0, 16'h0000);
        checkOutput("src_target_pc", pc, 16'h4FBD);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 16'h7777, 1'b0, 16'h0000);
        checkOutput("src_hold_pc", pc, 16'h4FBD);

        // Illegal strobe combination
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 16'h0000, 1'b1, 16'h0000);
        checkOutput("illegal_pc", pc, 16'h4FBD);
        checkOutput("illegal_err", {15'h0, br_err}, 16'h0001);
        checkOutput("illegal_no_pulse", {15'h0, br_taken}, 16'h0000);
        idle();
        checkOutput("illegal_err_sticky", {15'h0, br_err}, 16'h0001);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 16'h1234, 1'b0, 16'h0000);
        checkOutput("illegal_with_pcwrite_pc", pc, 16'h1234);

        // Reset during a taken branch cycle
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b1, 16'hFFFF);
        checkOutput("rst_mid_pc", pc, 16'h0100);
        checkOutput("rst_mid_ir", ir, 16'h0000);
        checkOutput("rst_mid_retired", retired, 16'h0000);
        checkOutput("rst_mid_br_taken", {15'h0, br_taken}, 16'h0000);
        checkOutput("rst_mid_br_err", {15'h0, br_err}, 16'h0000);
        checkOutput("rst_mid_pc_cur", pc_cur, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 16'h0000, 1'b0, 16'h0000);
        checkOutput("rst_target_cleared", pc, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/pc_ir_unit.md
PC_IR_UNIT -- requirements
Module: pc_ir_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports PCWrite, IRWrite, PCBEqCond and PCBNqCond, each input, 1 bit: control strobes from the controller.
REQ-005 SHALL have port PCSrc, input, 2 bits: next-PC source select.
REQ-006 SHALL have port alu_result, input, 16 bits: combinational ALU output.
REQ-007 SHALL have port alu_zero, input, 1 bit: ALU result equals zero.
REQ-008 SHALL have port imem_rdata, input, 16 bits: instruction word at address pc, combinational read.
REQ-009 SHALL have port pc, output, 16 bits: program counter, also the instruction-memory address.
REQ-010 SHALL have port pc_cur, output, 16 bits: address of the instruction currently held in ir.
REQ-011 SHALL have port ir, output, 16 bits: instruction register.
REQ-012 SHALL have ports opcode and func_field, each output, 4 bits: opcode = ir[15:12] and func_field = ir[3:0], driven combinationally.
REQ-013 SHALL have port br_taken, output, 1 bit: one-cycle pulse on each cycle a conditional branch updates pc.
REQ-014 SHALL have port br_err, output, 1 bit: sticky flag set on an illegal strobe combination.
REQ-015 SHALL have port retired, output, 16 bits: count of instruction loads into ir.

Function
REQ-016 SHALL load ir with imem_rdata and pc_cur with pc on each edge where IRWrite=1; otherwise ir and pc_cur SHALL hold.
REQ-017 SHALL keep an internal 1-bit decode flag that is set on the edge after an IRWrite=1 edge and cleared on the following edge, so it is high for exactly one cycle.
REQ-018 SHALL keep an internal 16-bit branch-target register that loads pc + sign-extended ir[7:0] (modulo 2^16) on the edge where the decode flag is 1, and holds otherwise.
REQ-019 SHALL compute the jump target as {pc_cur[15:12], ir[11:0]}.
REQ-020 SHALL assert the branch condition (cond) when exactly one strobe is set and it is satisfied: either PCBEqCond=1 with PCBNqCond=0 and alu_zero=1, or PCBNqCond=1 with PCBEqCond=0 and alu_zero=0.
REQ-021 SHALL derive the pc write enable as PCWrite OR cond.
REQ-022 SHALL select next pc by priority: if PCWrite=1, use PCSrc (00 = alu_result, 01 = jump target, 10 = branch-target register, 11 = hold pc); else if cond=1, use the branch-target register; else hold pc.
REQ-023 SHALL, when PCBEqCond=1 and PCBNqCond=1 in the same cycle, take no conditional branch, set br_err on that edge, and keep br_err set until reset; a PCWrite in that same cycle SHALL still apply.
REQ-024 SHALL register br_taken as 1 on the edge after a cycle with cond=1 and PCWrite=0, and as 0 otherwise.
REQ-025 SHALL, when IRWrite=1 and PCWrite=1 on the same edge, load ir from the pre-update pc address and then update pc, with no hazard.
REQ-026 SHALL increment retired by 1 on each IRWrite=1 edge, wrapping from 16'hFFFF to 16'h0000.
REQ-027 SHALL make address arithmetic modulo 2^16 with no overflow flag.

Reset
REQ-028 SHALL, on a clock edge with rst=1, set pc to RESET_PC and set pc_cur, ir, the branch-target register, retired, br_err, br_taken and the decode flag to 0.
REQ-029 SHALL give rst priority over every other input on the same edge, including mid-instruction and mid-branch.
REQ-030 SHALL drive opcode and func_field to 0 after reset, since ir = 0.

Verification
REQ-031 SHALL cover fetch: pc=0x0000, imem_rdata=0x8123, IRWrite=1, PCWrite=1, PCSrc=00, alu_result=0x0001 -> ir=0x8123, pc_cur=0x0000, pc=0x0001, opcode=0x8, retired=1.
REQ-032 SHALL cover BEQ taken: ir=0x40FE loaded at pc_cur=0x0010 with pc=0x0011, decode cycle passes (target=0x000F), then PCBEqCond=1, alu_zero=1 -> pc=0x000F and br_taken pulses for one cycle.
REQ-033 SHALL cover BNQ not taken: same setup, PCBNqCond=1, alu_zero=1 -> pc stays 0x0011 and br_taken=0.
REQ-034 SHALL cover jump: pc_cur=0x5000, ir=0x3ABC, PCWrite=1, PCSrc=01 -> pc=0x5ABC.
REQ-035 SHALL cover the illegal combination: PCBEqCond=1 and PCBNqCond=1 with alu_zero=1 -> pc unchanged and br_err=1, which stays set until a rst edge clears it.
REQ-036 SHALL cover reset mid-operation: rst=1 during a branch cycle with RESET_PC=0x0100 -> pc=0x0100, ir=0, retired=0, br_taken=0.
